// File: rtl/sm_cp0_irq_pkg.sv
// Shared definitions for the schoolMIPS coprocessor-0: register map,
// exception codes, field positions and default handler addresses.
package sm_cp0_irq_pkg;

  // Register numbers (only select 0 is implemented)
  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS  = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;
  localparam logic [2:0] REG_SEL0    = 3'd0;

  // Exception codes written to Cause.ExcCode
  typedef enum logic [4:0] {
    EXC_INT = 5'h00,
    EXC_RI  = 5'h0a,
    EXC_OV  = 5'h0c
  } exc_code_e;

  // Status field positions
  localparam int unsigned STATUS_IE    = 0;
  localparam int unsigned STATUS_EXL   = 1;
  localparam int unsigned STATUS_IM_LO = 8;

  // Cause field positions
  localparam int unsigned CAUSE_EXC_LO = 2;
  localparam int unsigned CAUSE_IP_LO  = 8;
  localparam int unsigned CAUSE_IV     = 23;
  localparam int unsigned CAUSE_DC     = 27;
  localparam int unsigned CAUSE_TI     = 30;

  // Default handler addresses
  localparam logic [31:0] EXC_BASE_DEF = 32'h0000_0100;
  localparam logic [31:0] VEC_BASE_DEF = 32'h0000_0200;

  // IP7 belongs to the timer, so at most five hardware lines fit in IP[6:2]
  function automatic int unsigned clamp_hw_irq(input int unsigned n);
    return (n > 5) ? 5 : n;
  endfunction

endpackage

// File: rtl/sm_cp0_irq_prio.sv
// Priority encoder: reports the highest set bit of an 8-bit pending vector.
module sm_cp0_irq_prio (
  input  logic [7:0] pend,
  output logic [2:0] idx,
  output logic       valid
);

  // Upward scan so the last (highest) set bit wins
  always_comb begin
    idx   = '0;
    valid = |pend;
    for (int unsigned i = 0; i < 8; i++) begin
      if (pend[i]) idx = 3'(i);
    end
  end

endmodule

// File: rtl/sm_cp0_irq.sv
// Coprocessor-0 for schoolMIPS: Status/Cause/EPC/Count/Compare, hardware
// and software interrupts, timer interrupt and optional vectored dispatch.
module sm_cp0_irq
  import sm_cp0_irq_pkg::*;
#(
  parameter int unsigned HW_IRQ_NUM = 6,
  parameter logic [31:0] EXC_BASE   = EXC_BASE_DEF,
  parameter logic [31:0] VEC_BASE   = VEC_BASE_DEF,
  parameter int unsigned VEC_SHIFT  = 5,
  parameter int unsigned COUNT_W    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           cp0_PC,
  output logic [31:0]           cp0_EPC,
  output logic [31:0]           cp0_ExcHandler,
  output logic                  cp0_ExcRequest,
  input  logic                  cp0_ExcEret,
  input  logic [4:0]            cp0_regNum,
  input  logic [2:0]            cp0_regSel,
  output logic [31:0]           cp0_regRD,
  input  logic [31:0]           cp0_regWD,
  input  logic                  cp0_regWE,
  input  logic [HW_IRQ_NUM-1:0] cp0_HwIrq,
  input  logic                  cp0_ExcRI,
  input  logic                  cp0_ExcOv,
  output logic                  cp0_TimerIrq
);

  localparam int unsigned HW_N = clamp_hw_irq(HW_IRQ_NUM);

  // Architectural state
  logic [COUNT_W-1:0] count_q,   count_d;
  logic [COUNT_W-1:0] compare_q, compare_d;
  logic               ti_q,      ti_d;
  logic [7:0]         im_q,      im_d;
  logic               exl_q,     exl_d;
  logic               ie_q,      ie_d;
  logic               dc_q,      dc_d;
  logic               iv_q,      iv_d;
  logic [1:0]         ip_sw_q,   ip_sw_d;
  logic [4:0]         ip_hw_q,   ip_hw_d;
  exc_code_e          code_q,    code_d;
  logic [31:0]        epc_q,     epc_d;
  logic               req_q,     req_d;
  logic [31:0]        handler_q, handler_d;

  // Take decision
  logic [7:0]  ip;
  logic [7:0]  pend;
  logic [2:0]  pend_idx;
  logic        pend_valid;
  logic        exc;
  logic        irq;
  logic        take;
  exc_code_e   take_code;
  logic [31:0] take_addr;

  // Write decode
  logic wr_sel0;
  logic wr_count;
  logic wr_compare;
  logic wr_status;
  logic wr_cause;
  logic wr_epc;

  // Lines above the clamp have no IP bit; fold them away explicitly
  logic unused_hw;
  assign unused_hw = ^cp0_HwIrq;

  assign ip   = {ti_q, ip_hw_q, ip_sw_q};
  assign pend = ip & im_q;

  sm_cp0_irq_prio u_prio (
    .pend  (pend),
    .idx   (pend_idx),
    .valid (pend_valid)
  );

  // Exception/interrupt take condition, cause code and handler address
  always_comb begin
    exc  = cp0_ExcRI | cp0_ExcOv;
    irq  = ie_q & pend_valid;
    take = (exc | irq) & ~exl_q;
    if (cp0_ExcRI)      take_code = EXC_RI;
    else if (cp0_ExcOv) take_code = EXC_OV;
    else                take_code = EXC_INT;
    if (exc || !iv_q) take_addr = EXC_BASE;
    else              take_addr = VEC_BASE + (32'(pend_idx) << VEC_SHIFT);
  end

  // mtc0 target decode
  always_comb begin
    wr_sel0    = cp0_regWE && (cp0_regSel == REG_SEL0);
    wr_count   = wr_sel0 && (cp0_regNum == REG_COUNT);
    wr_compare = wr_sel0 && (cp0_regNum == REG_COMPARE);
    wr_status  = wr_sel0 && (cp0_regNum == REG_STATUS);
    wr_cause   = wr_sel0 && (cp0_regNum == REG_CAUSE);
    wr_epc     = wr_sel0 && (cp0_regNum == REG_EPC);
  end

  // Next-state: software writes first, then eret, then hardware capture on take
  always_comb begin
    count_d   = count_q;
    compare_d = compare_q;
    ti_d      = ti_q;
    im_d      = im_q;
    exl_d     = exl_q;
    ie_d      = ie_q;
    dc_d      = dc_q;
    iv_d      = iv_q;
    ip_sw_d   = ip_sw_q;
    ip_hw_d   = '0;
    code_d    = code_q;
    epc_d     = epc_q;
    req_d     = take;
    handler_d = handler_q;

    for (int unsigned i = 0; i < HW_N; i++) ip_hw_d[i] = cp0_HwIrq[i];

    if (wr_count)   count_d = cp0_regWD[COUNT_W-1:0];
    else if (!dc_q) count_d = count_q + COUNT_W'(1);

    if (wr_compare) compare_d = cp0_regWD[COUNT_W-1:0];

    // Compare write clears TI and beats a simultaneous match
    if (wr_compare)                         ti_d = 1'b0;
    else if (!dc_q && count_q == compare_q) ti_d = 1'b1;

    if (wr_status) begin
      im_d  = cp0_regWD[STATUS_IM_LO +: 8];
      exl_d = cp0_regWD[STATUS_EXL];
      ie_d  = cp0_regWD[STATUS_IE];
    end

    if (wr_cause) begin
      ip_sw_d = cp0_regWD[CAUSE_IP_LO +: 2];
      dc_d    = cp0_regWD[CAUSE_DC];
      iv_d    = cp0_regWD[CAUSE_IV];
    end

    if (wr_epc) epc_d = cp0_regWD;

    if (cp0_ExcEret) exl_d = 1'b0;

    if (take) begin
      epc_d     = cp0_PC;
      code_d    = take_code;
      exl_d     = 1'b1;
      handler_d = take_addr;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= '0;
      compare_q <= '0;
      ti_q      <= 1'b0;
      im_q      <= '0;
      exl_q     <= 1'b0;
      ie_q      <= 1'b0;
      dc_q      <= 1'b0;
      iv_q      <= 1'b0;
      ip_sw_q   <= '0;
      ip_hw_q   <= '0;
      code_q    <= EXC_INT;
      epc_q     <= '0;
      req_q     <= 1'b0;
      handler_q <= EXC_BASE;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      ti_q      <= ti_d;
      im_q      <= im_d;
      exl_q     <= exl_d;
      ie_q      <= ie_d;
      dc_q      <= dc_d;
      iv_q      <= iv_d;
      ip_sw_q   <= ip_sw_d;
      ip_hw_q   <= ip_hw_d;
      code_q    <= code_d;
      epc_q     <= epc_d;
      req_q     <= req_d;
      handler_q <= handler_d;
    end
  end

  // mfc0 read mux; unimplemented registers and selects read zero
  always_comb begin
    cp0_regRD = '0;
    if (cp0_regSel == REG_SEL0) begin
      case (cp0_regNum)
        REG_COUNT:   cp0_regRD = 32'(count_q);
        REG_COMPARE: cp0_regRD = 32'(compare_q);
        REG_STATUS: begin
          cp0_regRD[STATUS_IM_LO +: 8] = im_q;
          cp0_regRD[STATUS_EXL]        = exl_q;
          cp0_regRD[STATUS_IE]         = ie_q;
        end
        REG_CAUSE: begin
          cp0_regRD[CAUSE_TI]          = ti_q;
          cp0_regRD[CAUSE_DC]          = dc_q;
          cp0_regRD[CAUSE_IV]          = iv_q;
          cp0_regRD[CAUSE_IP_LO +: 8]  = ip;
          cp0_regRD[CAUSE_EXC_LO +: 5] = code_q;
        end
        REG_EPC:     cp0_regRD = epc_q;
        default:     cp0_regRD = '0;
      endcase
    end
  end

  assign cp0_EPC        = epc_q;
  assign cp0_ExcHandler = handler_q;
  assign cp0_ExcRequest = req_q;
  assign cp0_TimerIrq   = ti_q;

endmodule

// File: tb/tb_sm_cp0_irq.sv
// Bench for sm_cp0_irq: directed scenarios, a behavioural CP0 model checked
// every cycle, and hand-computed literal expectations.
module tb_sm_cp0_irq;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cp0_PC;
  logic [31:0] cp0_EPC;
  logic [31:0] cp0_ExcHandler;
  logic        cp0_ExcRequest;
  logic        cp0_ExcEret;
  logic [4:0]  cp0_regNum;
  logic [2:0]  cp0_regSel;
  logic [31:0] cp0_regRD;
  logic [31:0] cp0_regWD;
  logic        cp0_regWE;
  logic [5:0]  cp0_HwIrq;
  logic        cp0_ExcRI;
  logic        cp0_ExcOv;
  logic        cp0_TimerIrq;

  // Second instance with an 8-bit Count
  logic        c8_we;
  logic [31:0] c8_wd;
  logic [31:0] c8_rd;
  logic [31:0] c8_epc, c8_handler;
  logic        c8_req, c8_ti;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sm_cp0_irq u_dut (
    .clk(clk), .rst(rst), .cp0_PC(cp0_PC), .cp0_EPC(cp0_EPC),
    .cp0_ExcHandler(cp0_ExcHandler), .cp0_ExcRequest(cp0_ExcRequest),
    .cp0_ExcEret(cp0_ExcEret), .cp0_regNum(cp0_regNum), .cp0_regSel(cp0_regSel),
    .cp0_regRD(cp0_regRD), .cp0_regWD(cp0_regWD), .cp0_regWE(cp0_regWE),
    .cp0_HwIrq(cp0_HwIrq), .cp0_ExcRI(cp0_ExcRI), .cp0_ExcOv(cp0_ExcOv),
    .cp0_TimerIrq(cp0_TimerIrq)
  );

  sm_cp0_irq #(.COUNT_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .cp0_PC(32'h0), .cp0_EPC(c8_epc),
    .cp0_ExcHandler(c8_handler), .cp0_ExcRequest(c8_req),
    .cp0_ExcEret(1'b0), .cp0_regNum(5'd9), .cp0_regSel(3'd0),
    .cp0_regRD(c8_rd), .cp0_regWD(c8_wd), .cp0_regWE(c8_we),
    .cp0_HwIrq(6'b0), .cp0_ExcRI(1'b0), .cp0_ExcOv(1'b0),
    .cp0_TimerIrq(c8_ti)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_count, m_compare, m_epc, m_handler;
  logic [7:0]  m_im;
  logic [4:0]  m_hw, m_code;
  logic [1:0]  m_sw;
  logic        m_ti, m_exl, m_ie, m_dc, m_iv, m_req;

  function automatic logic [7:0] m_ip();
    return {m_ti, m_hw, m_sw};
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] num, input logic [2:0] sel);
    if (sel != 3'd0) return 32'h0;
    case (num)
      5'd9:  return m_count;
      5'd11: return m_compare;
      5'd12: return (32'(m_im) << 8) | (32'(m_exl) << 1) | 32'(m_ie);
      5'd13: return (32'(m_ti) << 30) | (32'(m_dc) << 27) | (32'(m_iv) << 23)
                  | (32'(m_ip()) << 8) | (32'(m_code) << 2);
      5'd14: return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    logic [7:0]  pend;
    logic        exc, irq, take, wr;
    int          top;
    logic [31:0] n_count, n_compare, n_epc, n_handler;
    logic [7:0]  n_im;
    logic [4:0]  n_code;
    logic [1:0]  n_sw;
    logic        n_ti, n_exl, n_ie, n_dc, n_iv;
    if (rst) begin
      m_count = 0; m_compare = 0; m_epc = 0; m_handler = 32'h100;
      m_im = 0; m_hw = 0; m_code = 0; m_sw = 0;
      m_ti = 0; m_exl = 0; m_ie = 0; m_dc = 0; m_iv = 0; m_req = 0;
    end else begin
      pend = m_ip() & m_im;
      top  = -1;
      for (int b = 7; b >= 0; b--) if (pend[b] && top < 0) top = b;
      exc  = cp0_ExcRI || cp0_ExcOv;
      irq  = m_ie && (top >= 0);
      take = (exc || irq) && !m_exl;
      wr   = cp0_regWE && (cp0_regSel == 3'd0);

      n_count = m_count; n_compare = m_compare; n_epc = m_epc; n_handler = m_handler;
      n_im = m_im; n_code = m_code; n_sw = m_sw;
      n_ti = m_ti; n_exl = m_exl; n_ie = m_ie; n_dc = m_dc; n_iv = m_iv;

      if (wr && cp0_regNum == 9) n_count = cp0_regWD;
      else if (!m_dc)            n_count = m_count + 1;
      if (wr && cp0_regNum == 11) begin
        n_compare = cp0_regWD;
        n_ti = 0;
      end else if (!m_dc && m_count == m_compare) n_ti = 1;
      if (wr && cp0_regNum == 12) begin
        n_im = cp0_regWD[15:8]; n_exl = cp0_regWD[1]; n_ie = cp0_regWD[0];
      end
      if (wr && cp0_regNum == 13) begin
        n_sw = cp0_regWD[9:8]; n_dc = cp0_regWD[27]; n_iv = cp0_regWD[23];
      end
      if (wr && cp0_regNum == 14) n_epc = cp0_regWD;
      if (cp0_ExcEret) n_exl = 0;
      if (take) begin
        n_epc  = cp0_PC;
        n_exl  = 1;
        n_code = cp0_ExcRI ? 5'h0a : cp0_ExcOv ? 5'h0c : 5'h00;
        if (exc || !m_iv) n_handler = 32'h100;
        else              n_handler = 32'h200 + 32'(top) * 32;
      end

      m_count = n_count; m_compare = n_compare; m_epc = n_epc; m_handler = n_handler;
      m_im = n_im; m_code = n_code; m_sw = n_sw; m_ti = n_ti;
      m_exl = n_exl; m_ie = n_ie; m_dc = n_dc; m_iv = n_iv;
      m_req = take;
      m_hw  = cp0_HwIrq[4:0];
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      chk("m_req",     32'(cp0_ExcRequest), 32'(m_req));
      chk("m_epc",     cp0_EPC,             m_epc);
      chk("m_handler", cp0_ExcHandler,      m_handler);
      chk("m_ti",      32'(cp0_TimerIrq),   32'(m_ti));
      chk("m_rd",      cp0_regRD,           m_read(cp0_regNum, cp0_regSel));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mtc0(input logic [4:0] num, input logic [31:0] val);
    cp0_regWE = 1; cp0_regNum = num; cp0_regSel = 0; cp0_regWD = val;
    tick();
    cp0_regWE = 0;
  endtask

  task automatic eret();
    cp0_ExcEret = 1;
    tick();
    cp0_ExcEret = 0;
  endtask

  task automatic rd_chk(input string name, input logic [4:0] num, input logic [31:0] exp);
    cp0_regNum = num; cp0_regSel = 0;
    #1;
    chk(name, cp0_regRD, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1; cp0_PC = 0; cp0_ExcEret = 0; cp0_regNum = 0; cp0_regSel = 0;
    cp0_regWD = 0; cp0_regWE = 0; cp0_HwIrq = 0; cp0_ExcRI = 0; cp0_ExcOv = 0;
    c8_we = 0; c8_wd = 0;

    // Reset state
    #22;
    chk("rst_req",     32'(cp0_ExcRequest), 32'h0);
    chk("rst_handler", cp0_ExcHandler,      32'h100);
    chk("rst_epc",     cp0_EPC,             32'h0);
    chk("rst_ti",      32'(cp0_TimerIrq),   32'h0);
    rd_chk("rst_status", 5'd12, 32'h0);
    rst = 0;

    // Timer interrupt: Count==20 -> TI next edge -> strobe one edge later
    mtc0(5'd11, 32'd20);
    mtc0(5'd12, 32'h0000_8001);
    mtc0(5'd9,  32'd0);
    n = 0;
    while (n < 40 && !cp0_ExcRequest) begin
      tick();
      n++;
    end
    chk("timer_latency", 32'(n), 32'd22);
    chk("timer_handler", cp0_ExcHandler, 32'h100);
    rd_chk("timer_cause", 5'd13, 32'h4000_8000);
    tick();
    chk("timer_single", 32'(cp0_ExcRequest), 32'h0);
    mtc0(5'd11, 32'd20);
    chk("timer_clear", 32'(cp0_TimerIrq), 32'h0);
    eret();

    // Vectored dispatch: IP2 and IP4 pending, IP4 wins -> 0x200 + 4*32
    mtc0(5'd13, 32'h0080_0000);
    mtc0(5'd12, 32'h0000_FF01);
    cp0_PC = 32'h1000_0040; cp0_HwIrq = 6'b000101;
    tick();
    cp0_PC = 32'h1000_0080;
    rd_chk("vec_cause_ip", 5'd13, 32'h0080_1400);
    tick();
    chk("vec_req",     32'(cp0_ExcRequest), 32'h1);
    chk("vec_handler", cp0_ExcHandler,      32'h280);
    chk("vec_epc",     cp0_EPC,             32'h1000_0080);
    cp0_HwIrq = 0;
    tick();
    chk("vec_single", 32'(cp0_ExcRequest), 32'h0);
    eret();

    // Line beyond the clamp has no IP bit
    cp0_HwIrq = 6'b100000;
    tick();
    rd_chk("clamp_cause", 5'd13, 32'h0080_0000);
    tick();
    chk("clamp_noreq", 32'(cp0_ExcRequest), 32'h0);
    cp0_HwIrq = 0;

    // Exception precedence over interrupt and over each other
    cp0_HwIrq = 6'b000001; cp0_ExcRI = 1; cp0_ExcOv = 1;
    tick();
    chk("prec_req",     32'(cp0_ExcRequest), 32'h1);
    chk("prec_handler", cp0_ExcHandler,      32'h100);
    rd_chk("prec_cause", 5'd13, 32'h0080_0428);
    tick();
    chk("prec_single", 32'(cp0_ExcRequest), 32'h0);
    cp0_ExcRI = 0; cp0_ExcOv = 0; cp0_HwIrq = 0;
    tick();
    eret();

    // EXL masks exceptions; eret re-enables two edges later
    mtc0(5'd12, 32'h0000_FF03);
    cp0_ExcOv = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("exl_mask", 32'(cp0_ExcRequest), 32'h0);
    end
    eret();
    chk("eret_edge", 32'(cp0_ExcRequest), 32'h0);
    tick();
    chk("eret_take", 32'(cp0_ExcRequest), 32'h1);
    rd_chk("eret_cause", 5'd13, 32'h0080_0030);
    tick();
    chk("eret_single", 32'(cp0_ExcRequest), 32'h0);
    cp0_ExcOv = 0;
    eret();

    // EPC write coincident with take: hardware capture wins
    cp0_PC = 32'h0000_2000; cp0_ExcOv = 1;
    mtc0(5'd14, 32'hDEAD_0000);
    chk("epc_hw_wins", cp0_EPC, 32'h0000_2000);
    cp0_ExcOv = 0;
    eret();

    // Count freeze/resume; 8-bit count wraps
    mtc0(5'd13, 32'h0800_0000);
    mtc0(5'd9,  32'h0000_1234);
    tick(); tick(); tick();
    rd_chk("dc_freeze", 5'd9, 32'h0000_1234);
    mtc0(5'd13, 32'h0);
    rd_chk("dc_resume0", 5'd9, 32'h0000_1234);
    tick();
    rd_chk("dc_resume1", 5'd9, 32'h0000_1235);
    c8_we = 1; c8_wd = 32'h0000_00FE;
    tick();
    c8_we = 0;
    chk("c8_fe", c8_rd, 32'h0000_00FE);
    tick();
    chk("c8_ff", c8_rd, 32'h0000_00FF);
    tick();
    chk("c8_wrap", c8_rd, 32'h0000_0000);
    tick();
    chk("c8_01", c8_rd, 32'h0000_0001);

    // Software interrupt IP0 vectored, then async reset during the strobe
    mtc0(5'd13, 32'h0080_0100);
    tick();
    chk("sw_req",     32'(cp0_ExcRequest), 32'h1);
    chk("sw_handler", cp0_ExcHandler,      32'h200);
    #2 rst = 1;
    #1;
    chk("arst_req",     32'(cp0_ExcRequest), 32'h0);
    chk("arst_handler", cp0_ExcHandler,      32'h100);
    chk("arst_epc",     cp0_EPC,             32'h0);
    chk("arst_ti",      32'(cp0_TimerIrq),   32'h0);
    rd_chk("arst_cause", 5'd13, 32'h0);
    #1 rst = 0;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sm_cp0_irq.md
Name: sm_cp0_irq

Overview:
Parametrised coprocessor-0 for schoolMIPS: Status/Cause/EPC/Count/Compare with a configurable number of hardware interrupt lines. Adds a priority encoder, optional vectored interrupt dispatch (Cause.IV), a writable EPC and a configurable Count width. Sits beside the pipeline. The core reads and writes registers via mfc0/mtc0 and redirects fetch on cp0_ExcRequest to cp0_ExcHandler.

Parameters:
HW_IRQ_NUM, 6, number of hardware interrupt lines (1..5), mapped to Cause.IP[2+i]. Values above 5 are clamped, because IP7 is reserved for the timer.
EXC_BASE, 32'h0000_0100, general exception/non-vectored handler address.
VEC_BASE, 32'h0000_0200, vector table base when Cause.IV=1.
VEC_SHIFT, 5, log2 of vector spacing in bytes.
COUNT_W, 32, implemented Count/Compare width (8..32); upper bits read as 0.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
cp0_PC  in  32  PC to save on exception
cp0_EPC  out  32  return address
cp0_ExcHandler  out  32  handler/vector address, valid with cp0_ExcRequest
cp0_ExcRequest  out  1  one-cycle exception strobe
cp0_ExcEret  in  1  eret executed
cp0_regNum  in  5  mtc0/mfc0 register number
cp0_regSel  in  3  register select
cp0_regRD  out  32  read data (combinational)
cp0_regWD  in  32  write data
cp0_regWE  in  1  write enable
cp0_HwIrq  in  HW_IRQ_NUM  level-sensitive, already synchronous interrupts
cp0_ExcRI  in  1  reserved instruction
cp0_ExcOv  in  1  arithmetic overflow
cp0_TimerIrq  out  1  Cause.TI mirror

Behaviour:
- The reset is fixed: one clock, clk; asynchronous active-high rst.
- Reset values: all registers 0, cp0_ExcRequest=0, cp0_EPC=0, cp0_ExcHandler=EXC_BASE, cp0_TimerIrq=0.
- Register map, sel 0 only:
  - Count: reg 9.
  - Compare: reg 11.
  - Status: reg 12; IM[15:8], EXL[1], IE[0].
  - Cause: reg 13; TI[30], DC[27], IV[23], IP[15:8], ExcCode[6:2].
  - EPC: reg 14.
  - Any other num/sel reads 0; writes to it are ignored.
- Writable fields:
  - IP[1:0] (software interrupts), DC and IV via mtc0 Cause.
  - IM, EXL, IE via mtc0 Status.
  - EPC, Count, Compare fully writable.
- IP[2+i] is registered from cp0_HwIrq[i] every cycle and is not sticky. Unused IP bits read 0.
- Count: +1 per cycle when DC=0 and wraps at 2^COUNT_W. An mtc0 Count write beats the increment.
- TI (IP7):
  - Set on the edge after Count==Compare while DC=0.
  - Sticky; cleared only by an mtc0 Compare write.
  - The write wins over a simultaneous match.
- Take conditions, evaluated combinationally each cycle, with EXL as registered:
  - exc = RI | Ov
  - irq = IE & |(IP & IM)
  - take = (exc | irq) & ~EXL
- Priority: RI (code 0x0a) > Ov (0x0c) > Int (0x00).
- On the edge where take=1:
  - EPC <= cp0_PC
  - ExcCode <= code
  - EXL <= 1
  - cp0_ExcRequest <= 1
  - cp0_ExcHandler <= address, computed as:
    - EXC_BASE if the cause is an exception or IV=0;
    - otherwise VEC_BASE + (idx << VEC_SHIFT), where idx = highest set bit of IP&IM (0..7).
- Latency: one cycle from cause to strobe. The strobe drops on the next edge because EXL is now 1.
- cp0_ExcEret: EXL <= 0 on the next edge. A request pending in the same cycle is not taken (old EXL=1); it is taken one cycle later if still present.
- Simultaneous mtc0 Status write and take: IE/IM take the written value, EXL ends at 1 (hardware set wins).
- Simultaneous mtc0 EPC write and take: the hardware capture wins.
- Reset asserted mid-operation clears everything immediately, including a strobe in flight.

Decomposition:
- Shared header sm_cp0.vh holds:
  - register numbers/selects;
  - ExcCode constants (INT, RI, OV);
  - Status/Cause field bit positions;
  - EXC_BASE/VEC_BASE defaults.
- One sub-module, sm_cp0_prio: 8-bit pending vector in; 3-bit highest-index plus valid out; purely combinational.

Test Plan:
- Timer: write Compare=20, IM=8'h80, IE=1, Count=0 -> at Count==20, TI=1 next cycle. cp0_ExcRequest pulses once with ExcCode=0 and handler=EXC_BASE. Writing Compare clears TI.
- Vectored priority: IV=1, IM=8'hFF, IE=1; drive HwIrq=5'b00101 (IP2, IP4) -> handler=32'h0000_0280, EPC=cp0_PC of the take cycle.
- Exception precedence: assert cp0_ExcRI and cp0_ExcOv together with a pending irq -> ExcCode=0x0a, handler=EXC_BASE, a single strobe.
- EXL masking and eret: with EXL=1 raise Ov -> no strobe. Pulse eret with Ov still high -> strobe exactly 2 cycles after eret.
- Count control: DC=1 freezes Count at 0x1234. Clearing DC resumes counting. With COUNT_W=8, 0xFF wraps to 0x00.
- Async reset: assert rst mid-strobe -> all outputs 0 and cp0_ExcHandler=EXC_BASE without a clock edge.
